// File: rtl/spio_aer2spinn_mapper_cfg_if.sv
// AER pin handshake and SpiNNaker packet link bundle.
// slave = mapper side, master = pin/serialiser side.
interface spio_aer2spinn_mapper_cfg_if;
  logic [15:0] iaer_data;
  logic        iaer_req;
  logic        iaer_ack;
  logic [71:0] ipkt_data;
  logic        ipkt_vld;
  logic        ipkt_rdy;

  modport master (
    output iaer_data,
    output iaer_req,
    output ipkt_rdy,
    input  iaer_ack,
    input  ipkt_data,
    input  ipkt_vld
  );

  modport slave (
    input  iaer_data,
    input  iaer_req,
    input  ipkt_rdy,
    output iaer_ack,
    output ipkt_data,
    output ipkt_vld
  );
endinterface

// File: rtl/spio_aer2spinn_mapper_cfg.sv
// Configurable AER-to-SpiNNaker mapper: req sync, capture FSM,
// key mapping, packet FIFO, dump timeout and event counters.
module spio_aer2spinn_mapper_cfg #(
  parameter int FIFO_AW      = 2,
  parameter int TIMEOUT_BITS = 8,
  parameter int CNT_BITS     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             cfg_chip_addr,
  input  logic                    cfg_rotate,
  input  logic [2:0]              cfg_shift,
  input  logic                    cfg_direct,
  input  logic [TIMEOUT_BITS-1:0] cfg_timeout,
  spio_aer2spinn_mapper_cfg_if.slave bus,
  output logic                    dump_mode,
  output logic [CNT_BITS-1:0]     sent_cnt,
  output logic [CNT_BITS-1:0]     drop_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_C =
    {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic {IDLE, WTRQ} state_t;

  logic                    req_s1_q;
  logic                    reqs_q;
  state_t                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic [39:0]             mem_q [DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]        cnt_q, cnt_d;
  logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
  logic                    dump_q, dump_d;
  logic [CNT_BITS-1:0]     sent_q, sent_d;
  logic [CNT_BITS-1:0]     drop_q, drop_d;

  logic        empty, full, push, drop, pop;
  logic [6:0]  x, y, nx, ny, sx, sy;
  logic [1:0]  s;
  logic [14:0] coords;
  logic [38:0] upper;
  logic [39:0] key;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_C);
  assign pop   = !empty && bus.ipkt_rdy;

  assign bus.iaer_ack  = ack_q;
  assign bus.ipkt_vld  = !empty;
  assign bus.ipkt_data =
    empty ? 72'd0 : {32'd0, mem_q[rd_ptr_q]};
  assign dump_mode = dump_q;
  assign sent_cnt  = sent_q;
  assign drop_cnt  = drop_q;

  // Map the event on the pins to a 40-bit key with odd parity.
  always_comb begin
    x  = bus.iaer_data[7:1];
    y  = bus.iaer_data[14:8];
    s  = cfg_shift[2] ? 2'd3 : cfg_shift[1:0];
    nx = cfg_rotate ? ~y : x;
    ny = cfg_rotate ? ~x : y;
    sx = nx >> s;
    sy = ny >> s;
    coords = {bus.iaer_data[0], 14'd0}
           | ({8'd0, sy} << (3'd7 - {1'b0, s}))
           | {8'd0, sx};
    if (cfg_direct) coords = bus.iaer_data[14:0];
    upper = {cfg_chip_addr, bus.iaer_data[15],
             coords, 7'd0};
    key = {upper, ~^upper};
  end

  // Handshake FSM, FIFO bookkeeping, timeout and counters.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    push     = 1'b0;
    drop     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    dump_d   = 1'b0;
    sent_d   = sent_q;
    drop_d   = drop_q;
    unique case (state_q)
      IDLE: begin
        if (!reqs_q && dump_q) begin
          drop    = 1'b1;
          ack_d   = 1'b0;
          state_d = WTRQ;
        end else if (!reqs_q && !full) begin
          push    = 1'b1;
          ack_d   = 1'b0;
          state_d = WTRQ;
        end
      end
      WTRQ: begin
        if (reqs_q) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (FIFO_AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (FIFO_AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (bus.ipkt_rdy || empty)
      tmo_d = cfg_timeout;
    else if (tmo_q != '0)
      tmo_d = tmo_q - TIMEOUT_BITS'(1);
    dump_d = (tmo_q == '0) && (cfg_timeout != '0)
           && !bus.ipkt_rdy;
    if (pop && (sent_q != '1))
      sent_d = sent_q + CNT_BITS'(1);
    if (drop && (drop_q != '1))
      drop_d = drop_q + CNT_BITS'(1);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_s1_q <= 1'b1;
      reqs_q   <= 1'b1;
      state_q  <= IDLE;
      ack_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '1;
      dump_q   <= 1'b0;
      sent_q   <= '0;
      drop_q   <= '0;
    end else begin
      req_s1_q <= bus.iaer_req;
      reqs_q   <= req_s1_q;
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      dump_q   <= dump_d;
      sent_q   <= sent_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage; contents are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= key;
  end

endmodule

// File: tb/tb_spio_aer2spinn_mapper_cfg.sv
// Randomised scoreboard bench for the configurable AER mapper.
// Expected packets are queued at ack time and popped by a monitor.
module tb_spio_aer2spinn_mapper_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_chip_addr = 16'h0;
  logic        cfg_rotate = 1'b0;
  logic [2:0]  cfg_shift = 3'd0;
  logic        cfg_direct = 1'b0;
  logic [7:0]  cfg_timeout = 8'd0;
  logic        dump_mode;
  logic [31:0] sent_cnt;
  logic [31:0] drop_cnt;

  spio_aer2spinn_mapper_cfg_if bus();

  spio_aer2spinn_mapper_cfg dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_chip_addr (cfg_chip_addr),
    .cfg_rotate    (cfg_rotate),
    .cfg_shift     (cfg_shift),
    .cfg_direct    (cfg_direct),
    .cfg_timeout   (cfg_timeout),
    .bus           (bus.slave),
    .dump_mode     (dump_mode),
    .sent_cnt      (sent_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sent_model = 0;
  bit rnd_rdy = 0;
  logic [71:0] exp_q [$];

  function automatic void chk(input string name,
                              input logic [71:0] act,
                              input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [39:0] ref_key(
    input logic [15:0] d, input logic [15:0] chip,
    input bit rot, input int shift, input bit dir);
    int x, y, nx, ny, s, sx, sy, coords;
    logic [38:0] up;
    logic par;
    x = int'(d[7:1]);
    y = int'(d[14:8]);
    if (dir) coords = int'(d[14:0]);
    else begin
      nx = rot ? 127 - y : x;
      ny = rot ? 127 - x : y;
      s  = (shift > 3) ? 3 : shift;
      sx = nx / (1 << s);
      sy = ny / (1 << s);
      coords = int'(d[0]) * (1 << 14) + sy * (1 << (7 - s)) + sx;
    end
    up  = {chip, d[15], coords[14:0], 7'd0};
    par = ($countones(up) % 2 == 0);
    return {up, par};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.iaer_ack === lvl) begin
        ok = 1;
        break;
      end
      cyc(1);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: ack never reached %b", lvl);
    end
  endtask

  task automatic aer_send(input logic [15:0] d,
                          input bit do_push,
                          input logic [71:0] e);
    bit ok;
    bus.iaer_data = d;
    bus.iaer_req  = 1'b0;
    wait_ack(1'b0, ok);
    if (ok && do_push) exp_q.push_back(e);
    bus.iaer_req = 1'b1;
    wait_ack(1'b1, ok);
  endtask

  task automatic send_model(input logic [15:0] d);
    aer_send(d, 1'b1, {32'd0, ref_key(d, cfg_chip_addr,
             cfg_rotate, int'(cfg_shift), cfg_direct)});
  endtask

  task automatic drain();
    bit done;
    done = 0;
    bus.ipkt_rdy = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0 && bus.ipkt_vld === 1'b0) begin
        done = 1;
        break;
      end
      cyc(1);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d packets still expected", exp_q.size());
    end
  endtask

  // Ready randomiser for the random traffic phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.ipkt_rdy = 1'($urandom_range(0, 1));
  end

  // Monitor: pop and compare on every accepted packet,
  // and check the head holds still while stalled.
  initial begin
    bit hold;
    logic [71:0] hold_data;
    logic [71:0] e;
    hold = 0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst) hold = 0;
      else begin
        if (hold) begin
          chk("hold_vld", 72'(bus.ipkt_vld), 72'd1);
          chk("hold_data", bus.ipkt_data, hold_data);
        end
        if (bus.ipkt_vld === 1'b1 && bus.ipkt_rdy === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pkt: got %h expected none",
                     bus.ipkt_data);
          end else begin
            e = exp_q.pop_front();
            chk("pkt", bus.ipkt_data, e);
          end
          sent_model++;
        end
        hold = (bus.ipkt_vld === 1'b1) && (bus.ipkt_rdy === 1'b0);
        hold_data = bus.ipkt_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit seen;
    logic [15:0] d;
    bus.iaer_data = 16'h0;
    bus.iaer_req  = 1'b1;
    bus.ipkt_rdy  = 1'b0;
    cyc(3);
    chk("rst_ack", 72'(bus.iaer_ack), 72'd1);
    chk("rst_vld", 72'(bus.ipkt_vld), 72'd0);
    chk("rst_data", bus.ipkt_data, 72'd0);
    chk("rst_dump", 72'(dump_mode), 72'd0);
    chk("rst_sent", 72'(sent_cnt), 72'd0);
    chk("rst_drop", 72'(drop_cnt), 72'd0);
    rst = 1'b0;
    cyc(2);

    // Directed key mappings.
    bus.ipkt_rdy  = 1'b1;
    cfg_chip_addr = 16'h0200;
    cfg_rotate = 1'b1;
    cfg_shift  = 3'd0;
    cfg_direct = 1'b0;
    aer_send(16'h0203, 1'b1, 72'h00_0000_0002_007F_7D01);
    drain();
    chk("sent_one", 72'(sent_cnt), 72'd1);
    cfg_rotate = 1'b0;
    cfg_shift  = 3'd3;
    aer_send(16'h7FFF, 1'b1, 72'h00_0000_0002_0040_FF01);
    cfg_direct = 1'b1;
    cfg_rotate = 1'b1;
    cfg_shift  = 3'd2;
    aer_send(16'hFFFF, 1'b1, 72'h00_0000_0002_00FF_FF00);
    drain();
    chk("sent_three", 72'(sent_cnt), 72'(sent_model));

    // Full FIFO holds off the fifth handshake.
    cfg_direct = 1'b0;
    cfg_rotate = 1'b0;
    cfg_shift  = 3'd1;
    bus.ipkt_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_model(16'($urandom));
    chk("full_vld", 72'(bus.ipkt_vld), 72'd1);
    d = 16'($urandom);
    bus.iaer_data = d;
    bus.iaer_req  = 1'b0;
    cyc(20);
    chk("full_hold_ack", 72'(bus.iaer_ack), 72'd1);
    bus.ipkt_rdy = 1'b1;
    cyc(1);
    bus.ipkt_rdy = 1'b0;
    wait_ack(1'b0, ok);
    if (ok) exp_q.push_back({32'd0, ref_key(d, cfg_chip_addr,
                            cfg_rotate, int'(cfg_shift), cfg_direct)});
    bus.iaer_req = 1'b1;
    wait_ack(1'b1, ok);
    chk("full_depth", 72'(exp_q.size()), 72'd4);
    drain();

    // Dump timeout: drop while stalled, keep buffered packet.
    cfg_timeout  = 8'd16;
    bus.ipkt_rdy = 1'b0;
    send_model(16'($urandom));
    chk("dump_early", 72'(dump_mode), 72'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (dump_mode === 1'b1) begin
        seen = 1;
        break;
      end
      cyc(1);
    end
    chk("dump_rise", 72'(seen), 72'd1);
    for (int i = 0; i < 3; i++) aer_send(16'($urandom), 1'b0, 72'd0);
    chk("drop_cnt", 72'(drop_cnt), 72'd3);
    chk("dump_vld", 72'(bus.ipkt_vld), 72'd1);
    if (exp_q.size() == 1) chk("dump_head", bus.ipkt_data, exp_q[0]);
    else chk("dump_qsize", 72'(exp_q.size()), 72'd1);
    bus.ipkt_rdy = 1'b1;
    cyc(2);
    chk("dump_clear", 72'(dump_mode), 72'd0);
    drain();
    cfg_timeout = 8'd0;

    // Random traffic with random cfg and random ready.
    rnd_rdy = 1;
    for (int n = 0; n < 200; n++) begin
      cfg_chip_addr = 16'($urandom);
      cfg_rotate = 1'($urandom);
      cfg_shift  = 3'($urandom);
      cfg_direct = ($urandom_range(0, 3) == 0);
      send_model(16'($urandom));
    end
    rnd_rdy = 0;
    cyc(1);
    drain();
    chk("sent_rand", 72'(sent_cnt), 72'(sent_model));
    chk("drop_rand", 72'(drop_cnt), 72'd3);

    // Reset with buffered events discards them.
    bus.ipkt_rdy = 1'b0;
    for (int i = 0; i < 3; i++) aer_send(16'($urandom), 1'b0, 72'd0);
    chk("pre_rst_vld", 72'(bus.ipkt_vld), 72'd1);
    rst = 1'b1;
    #2;
    chk("mid_rst_vld", 72'(bus.ipkt_vld), 72'd0);
    chk("mid_rst_ack", 72'(bus.iaer_ack), 72'd1);
    chk("mid_rst_sent", 72'(sent_cnt), 72'd0);
    chk("mid_rst_drop", 72'(drop_cnt), 72'd0);
    cyc(2);
    sent_model = 0;
    rst = 1'b0;
    bus.ipkt_rdy = 1'b1;
    cyc(10);
    chk("post_rst_vld", 72'(bus.ipkt_vld), 72'd0);
    chk("post_rst_sent", 72'(sent_cnt), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
